// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid stage: state encoding and
// occupancy width, plus a helper mapping a state to its entry count.
package pipe_pkg;

  // Width of the occupancy output (0, 1 or 2 held entries).
  localparam int OCC_W = 2;

  // EMPTY: nothing held. BUSY: output register full. FULL: output and skid full.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  // Number of entries held in a given state.
  function automatic logic [OCC_W-1:0] occ_of(pipe_state_e s);
    logic [OCC_W-1:0] occ;
    occ = '0;
    case (s)
      EMPTY:   occ = 2'd0;
      BUSY:    occ = 2'd1;
      FULL:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter: adds inc_i when en_i is high, clamping at the
// all-ones value instead of wrapping. Cleared by asynchronous reset.
module pipe_sat_counter #(
  parameter int WIDTH = 16,
  parameter int INC_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [INC_W-1:0] inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  // The sum is one bit wider than the larger operand so that overflow past
  // the all-ones value is visible and can be clamped.
  localparam int SUM_W = ((WIDTH > INC_W) ? WIDTH : INC_W) + 1;

  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("pipe_sat_counter: WIDTH must be at least 1");
    end
    if (INC_W < 1) begin : g_bad_inc_w
      $error("pipe_sat_counter: INC_W must be at least 1");
    end
  endgenerate

  logic [WIDTH-1:0] cnt_q;
  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] max_ext;

  assign sum     = SUM_W'(cnt_q) + SUM_W'(inc_i);
  assign max_ext = SUM_W'({WIDTH{1'b1}});

  // Accumulate on enable, clamping at the maximum representable count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      if (sum > max_ext) begin
        cnt_q <= {WIDTH{1'b1}};
      end else begin
        cnt_q <= sum[WIDTH-1:0];
      end
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry registered pipeline stage with a skid buffer, stall and flush.
//
// Handshake: an entry moves upstream->stage on a cycle where valid_i and
// ready_o are both 1, and stage->downstream on a cycle where valid_o and
// ready_i are both 1 with neither stall_i nor flush_i asserted. ready_o is
// combinational from the registered state and the stall/flush inputs only,
// never from valid_i or ready_i. valid_o/data_o come straight from registers.
//
// Flush empties the stage (bubble) and counts the discarded entries;
// stall freezes every register. Flush wins over stall.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              ready_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic [OCC_W-1:0]  occ_o,
  output logic [CNT_W-1:0]  flush_cnt_o,
  output logic [1:0]        state_dbg_o
);

  generate
    if (CTRL_W < 1 || CTRL_W > DATA_W) begin : g_bad_ctrl_w
      $error("pipe_skid_stage: CTRL_W must be within 1..DATA_W");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
      $error("pipe_skid_stage: CNT_W must be at least 1");
    end
  endgenerate

  pipe_state_e       state_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] skid_q;

  logic              accept;
  logic              xfer;

  // Upstream may push whenever there is room and the stage is not frozen or
  // being emptied.
  assign ready_o = (state_q != FULL) && !stall_i && !flush_i;
  assign accept  = valid_i && ready_o;
  assign xfer    = valid_o && ready_i && !stall_i && !flush_i;

  assign valid_o     = (state_q != EMPTY);
  assign occ_o       = occ_of(state_q);
  assign data_o      = data_q;
  assign state_dbg_o = state_q;

  // Stage FSM: output register and skid register move together with state.
  // Leaving to EMPTY always zeroes the output register so a bubble carries
  // zero control bits (a NOP downstream).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      data_q  <= '0;
      skid_q  <= '0;
    end else if (flush_i) begin
      state_q <= EMPTY;
      data_q  <= '0;
      skid_q  <= '0;
    end else if (!stall_i) begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_q <= BUSY;
            data_q  <= data_i;
          end
        end
        BUSY: begin
          if (accept && xfer) begin
            data_q <= data_i;
          end else if (accept) begin
            state_q <= FULL;
            skid_q  <= data_i;
          end else if (xfer) begin
            state_q <= EMPTY;
            data_q  <= '0;
          end
        end
        FULL: begin
          if (xfer) begin
            state_q <= BUSY;
            data_q  <= skid_q;
            skid_q  <= '0;
          end
        end
        default: begin
          state_q <= EMPTY;
          data_q  <= '0;
          skid_q  <= '0;
        end
      endcase
    end
  end

  // Entries discarded by a flush: exactly the current occupancy. Reset clears
  // the count rather than adding to it.
  pipe_sat_counter #(
    .WIDTH (CNT_W),
    .INC_W (OCC_W)
  ) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (flush_i),
    .inc_i (occ_o),
    .cnt_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage. The reference is a plain FIFO of held entries
// (at most two) plus a saturating flush tally; a monitor compares every cycle.
module tb_pipe_skid_stage;

  localparam int DATA_W  = 96;
  localparam int CTRL_W  = 8;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // Clock / reset
  logic clk;
  logic rst_i;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic              valid_i;
  logic [DATA_W-1:0] data_i;
  logic              ready_o;
  logic              valid_o;
  logic [DATA_W-1:0] data_o;
  logic              ready_i;
  logic              stall_i;
  logic              flush_i;
  logic [1:0]        occ_o;
  logic [CNT_W-1:0]  flush_cnt_o;
  logic [1:0]        state_dbg_o;

  pipe_skid_stage #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .data_i      (data_i),
    .ready_o     (ready_o),
    .valid_o     (valid_o),
    .data_o      (data_o),
    .ready_i     (ready_i),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .occ_o       (occ_o),
    .flush_cnt_o (flush_cnt_o),
    .state_dbg_o (state_dbg_o)
  );

  // Scoreboard state
  logic [DATA_W-1:0] exp_q[$];
  int                flush_model;
  int                n_checks;
  int                n_fail;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: samples 1 time unit before each rising edge, checks outputs
  // against the model, then advances the model by what that edge will do.
  initial begin : monitor
    bit m_ready;
    int sz;
    forever begin
      @(negedge clk);
      #4;
      if (rst_i) begin
        exp_q.delete();
        flush_model = 0;
      end else begin
        sz      = exp_q.size();
        m_ready = (sz < 2) && !stall_i && !flush_i;
        check("occ_o", DATA_W'(occ_o), DATA_W'(sz));
        check("valid_o", DATA_W'(valid_o), DATA_W'(sz != 0));
        check("ready_o", DATA_W'(ready_o), DATA_W'(m_ready));
        check("flush_cnt_o", DATA_W'(flush_cnt_o), DATA_W'(flush_model));
        if (sz == 0) check("bubble_ctrl", DATA_W'(data_o[CTRL_W-1:0]), '0);
        else         check("data_o", data_o, exp_q[0]);
        if (flush_i) begin
          flush_model = flush_model + sz;
          if (flush_model > CNT_MAX) flush_model = CNT_MAX;
          exp_q.delete();
        end else begin
          if (sz != 0 && ready_i && !stall_i) void'(exp_q.pop_front());
          if (valid_i && m_ready) exp_q.push_back(data_i);
        end
      end
    end
  end

  // Driver: apply one cycle of inputs at the falling edge.
  task automatic drive(input bit v, input logic [DATA_W-1:0] d, input bit rdy,
                       input bit st, input bit fl);
    @(negedge clk);
    valid_i = v;
    data_i  = d;
    ready_i = rdy;
    stall_i = st;
    flush_i = fl;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // Fill an empty stage with two entries while downstream is blocked.
  task automatic fill2(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    drive(1'b1, a, 1'b0, 1'b0, 1'b0);
    drive(1'b1, b, 1'b0, 1'b0, 1'b0);
  endtask

  // Assert reset between edges and confirm outputs clear before the next edge.
  task automatic async_reset();
    @(negedge clk);
    valid_i = 1'b0; data_i = '0; ready_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    #1 rst_i = 1'b1;
    #1;
    check("rst_valid_o", DATA_W'(valid_o), '0);
    check("rst_occ_o", DATA_W'(occ_o), '0);
    check("rst_data_o", data_o, '0);
    check("rst_flush_cnt", DATA_W'(flush_cnt_o), '0);
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  initial begin : stimulus
    logic [DATA_W-1:0] rd;
    n_checks = 0; n_fail = 0; flush_model = 0;
    rst_i = 1'b1;
    valid_i = 1'b0; data_i = '0; ready_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;

    // Single entry with immediate latency.
    drive(1'b1, 96'h0A, 1'b1, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle();

    // Back-pressure into FULL, third entry held upstream, then drain in order.
    drive(1'b1, 96'h01, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 96'h02, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 96'h03, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 96'h03, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 96'h03, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 96'h03, 1'b1, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Stall while FULL with downstream ready, then release.
    fill2(96'h11, 96'h22);
    repeat (3) drive(1'b1, 96'h33, 1'b1, 1'b1, 1'b0);
    repeat (3) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Flush of FULL overriding stall; output register must be all zero.
    fill2(96'hAA5500FF, 96'hBB66);
    drive(1'b1, 96'hCC, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #1 check("flush_data_zero", data_o, '0);
    idle();

    // Second flush of FULL saturates the narrow counter.
    fill2(96'h44, 96'h55);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle();
    fill2(96'h66, 96'h77);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
    idle();

    // Asynchronous reset while FULL, then the first edge accepts normally.
    fill2(96'h88, 96'h99);
    async_reset();
    drive(1'b1, 96'h5A00, 1'b1, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle();

    // Randomized traffic with occasional stall, flush and reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        async_reset();
      end else begin
        rd = {$urandom(), $urandom(), $urandom()};
        drive($urandom_range(0, 3) != 0, rd, $urandom_range(0, 2) != 0,
              $urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0);
      end
    end
    repeat (4) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #6;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
